// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: ALU reservation station with CDB operand capture and lowest-index issue.
module rs_issue_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int RS_LOG = 4,
    parameter int ROB_LOG = 4,
    parameter int OP_LOG = 6,
    parameter logic [OP_LOG-1:0] OP_NOP = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rdy,
    input  logic               i_flush,
    input  logic               i_disp_valid,
    input  logic [OP_LOG-1:0]  i_disp_op,
    input  logic [31:0]        i_disp_vj,
    input  logic [31:0]        i_disp_vk,
    input  logic               i_disp_qj_busy,
    input  logic               i_disp_qk_busy,
    input  logic [ROB_LOG-1:0] i_disp_qj,
    input  logic [ROB_LOG-1:0] i_disp_qk,
    input  logic [31:0]        i_disp_imm,
    input  logic [ROB_LOG-1:0] i_disp_dest_rob,
    input  logic [31:0]        i_disp_cur_pc,
    output logic               o_rs_full,
    input  logic               i_cdb0_en,
    input  logic [ROB_LOG-1:0] i_cdb0_rob,
    input  logic [31:0]        i_cdb0_val,
    input  logic               i_cdb1_en,
    input  logic [ROB_LOG-1:0] i_cdb1_rob,
    input  logic [31:0]        i_cdb1_val,
    output logic               o_rs_valid,
    output logic [OP_LOG-1:0]  o_rs_op,
    output logic [31:0]        o_rs_vj,
    output logic [31:0]        o_rs_vk,
    output logic [31:0]        o_rs_imm,
    output logic [31:0]        o_rs_cur_pc,
    output logic [ROB_LOG-1:0] o_rs_dest_rob
);
    logic [RS_SIZE-1:0] r_busy, r_qj_busy, r_qk_busy;
    logic [OP_LOG-1:0]  r_op [RS_SIZE];
    logic [31:0]        r_vj [RS_SIZE];
    logic [31:0]        r_vk [RS_SIZE];
    logic [31:0]        r_imm [RS_SIZE];
    logic [31:0]        r_pc [RS_SIZE];
    logic [ROB_LOG-1:0] r_qj [RS_SIZE];
    logic [ROB_LOG-1:0] r_qk [RS_SIZE];
    logic [ROB_LOG-1:0] r_dest [RS_SIZE];
    logic [RS_SIZE-1:0] w_ready;
    logic [RS_LOG-1:0]  w_iss_idx, w_free_idx;
    logic               w_iss_any;
    assign o_rs_full = &r_busy;
    assign w_ready = r_busy & ~r_qj_busy & ~r_qk_busy;
    // Downward scans so the last hit is the lowest index.
    always_comb begin
        w_iss_idx = '0;
        w_free_idx = '0;
        w_iss_any = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_iss_idx = i[RS_LOG-1:0];
                w_iss_any = 1'b1;
            end
            if (!r_busy[i]) w_free_idx = i[RS_LOG-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst || (i_rdy && i_flush)) begin
            r_busy <= '0;
            o_rs_valid <= 1'b0;
            o_rs_op <= OP_NOP;
            o_rs_vj <= '0;
            o_rs_vk <= '0;
            o_rs_imm <= '0;
            o_rs_cur_pc <= '0;
            o_rs_dest_rob <= '0;
        end else if (i_rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_busy[i] && i_cdb0_en && r_qj[i] == i_cdb0_rob) begin
                    r_vj[i] <= i_cdb0_val;
                    r_qj_busy[i] <= 1'b0;
                end else if (r_busy[i] && r_qj_busy[i] && i_cdb1_en && r_qj[i] == i_cdb1_rob) begin
                    r_vj[i] <= i_cdb1_val;
                    r_qj_busy[i] <= 1'b0;
                end
                if (r_busy[i] && r_qk_busy[i] && i_cdb0_en && r_qk[i] == i_cdb0_rob) begin
                    r_vk[i] <= i_cdb0_val;
                    r_qk_busy[i] <= 1'b0;
                end else if (r_busy[i] && r_qk_busy[i] && i_cdb1_en && r_qk[i] == i_cdb1_rob) begin
                    r_vk[i] <= i_cdb1_val;
                    r_qk_busy[i] <= 1'b0;
                end
            end
            o_rs_valid <= w_iss_any;
            if (w_iss_any) begin
                r_busy[w_iss_idx] <= 1'b0;
                o_rs_op <= r_op[w_iss_idx];
                o_rs_vj <= r_vj[w_iss_idx];
                o_rs_vk <= r_vk[w_iss_idx];
                o_rs_imm <= r_imm[w_iss_idx];
                o_rs_cur_pc <= r_pc[w_iss_idx];
                o_rs_dest_rob <= r_dest[w_iss_idx];
            end else begin
                o_rs_op <= OP_NOP;
            end
            // The free slot is never the issuing one, so wakeup/issue writes cannot collide.
            if (i_disp_valid && !o_rs_full) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx] <= i_disp_op;
                r_imm[w_free_idx] <= i_disp_imm;
                r_pc[w_free_idx] <= i_disp_cur_pc;
                r_dest[w_free_idx] <= i_disp_dest_rob;
                r_qj[w_free_idx] <= i_disp_qj;
                r_qk[w_free_idx] <= i_disp_qk;
                r_vj[w_free_idx] <= !i_disp_qj_busy ? i_disp_vj :
                                    (i_cdb0_en && i_cdb0_rob == i_disp_qj) ? i_cdb0_val :
                                    (i_cdb1_en && i_cdb1_rob == i_disp_qj) ? i_cdb1_val : i_disp_vj;
                r_vk[w_free_idx] <= !i_disp_qk_busy ? i_disp_vk :
                                    (i_cdb0_en && i_cdb0_rob == i_disp_qk) ? i_cdb0_val :
                                    (i_cdb1_en && i_cdb1_rob == i_disp_qk) ? i_cdb1_val : i_disp_vk;
                r_qj_busy[w_free_idx] <= i_disp_qj_busy && !(i_cdb0_en && i_cdb0_rob == i_disp_qj)
                                         && !(i_cdb1_en && i_cdb1_rob == i_disp_qj);
                r_qk_busy[w_free_idx] <= i_disp_qk_busy && !(i_cdb0_en && i_cdb0_rob == i_disp_qk)
                                         && !(i_cdb1_en && i_cdb1_rob == i_disp_qk);
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed checks of dispatch, wakeup, issue order, full, flush and freeze.
module tb_rs_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst, rdy, flush, disp_valid, qj_busy, qk_busy, cdb0_en, cdb1_en;
    logic [5:0]  disp_op;
    logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc, cdb0_val, cdb1_val;
    logic [3:0]  disp_qj, disp_qk, disp_dest, cdb0_rob, cdb1_rob;
    logic        rs_full, rs_valid;
    logic [5:0]  rs_op;
    logic [31:0] rs_vj, rs_vk, rs_imm, rs_pc;
    logic [3:0]  rs_dest;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rs_issue_scheduler dut (
        .clk(clk), .rst(rst), .i_rdy(rdy), .i_flush(flush),
        .i_disp_valid(disp_valid), .i_disp_op(disp_op), .i_disp_vj(disp_vj), .i_disp_vk(disp_vk),
        .i_disp_qj_busy(qj_busy), .i_disp_qk_busy(qk_busy), .i_disp_qj(disp_qj), .i_disp_qk(disp_qk),
        .i_disp_imm(disp_imm), .i_disp_dest_rob(disp_dest), .i_disp_cur_pc(disp_pc),
        .o_rs_full(rs_full),
        .i_cdb0_en(cdb0_en), .i_cdb0_rob(cdb0_rob), .i_cdb0_val(cdb0_val),
        .i_cdb1_en(cdb1_en), .i_cdb1_rob(cdb1_rob), .i_cdb1_val(cdb1_val),
        .o_rs_valid(rs_valid), .o_rs_op(rs_op), .o_rs_vj(rs_vj), .o_rs_vk(rs_vk),
        .o_rs_imm(rs_imm), .o_rs_cur_pc(rs_pc), .o_rs_dest_rob(rs_dest)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0; qj_busy = 1'b0; qk_busy = 1'b0;
        cdb0_en = 1'b0; cdb1_en = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0;
        disp_pc = '0; cdb0_val = '0; cdb1_val = '0; disp_qj = '0; disp_qk = '0; disp_dest = '0;
        cdb0_rob = '0; cdb1_rob = '0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] vj, vk, imm,
                        input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk);
        disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk; disp_imm = imm;
        qj_busy = qjb; disp_qj = qj; qk_busy = qkb; disp_qk = qk;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        step(); step();
        chk("rst_valid", rs_valid, 0); chk("rst_op", rs_op, 0); chk("rst_full", rs_full, 0);
        chk("rst_vj", rs_vj, 0);
        rst = 1'b1;
        // ADD with ready operands
        disp(6'd1, 5, 7, 0, 0, 0, 0, 0); disp_dest = 4'd3;
        step(); disp_valid = 1'b0;
        chk("add_lat0", rs_valid, 0);
        step();
        chk("add_valid", rs_valid, 1); chk("add_op", rs_op, 1); chk("add_vj", rs_vj, 5);
        chk("add_vk", rs_vk, 7); chk("add_dest", rs_dest, 3);
        step();
        chk("add_after", rs_valid, 0); chk("add_nop", rs_op, 0);
        // ADDI waiting on rob 6 via cdb1
        disp(6'd2, 0, 0, 1, 1, 6, 0, 0); disp_pc = 32'h100;
        step(); disp_valid = 1'b0;
        step();
        chk("addi_wait", rs_valid, 0);
        cdb1_en = 1'b1; cdb1_rob = 4'd6; cdb1_val = 9;
        step(); cdb1_en = 1'b0;
        chk("addi_wake_edge", rs_valid, 0);
        step();
        chk("addi_valid", rs_valid, 1); chk("addi_vj", rs_vj, 9); chk("addi_imm", rs_imm, 1);
        chk("addi_op", rs_op, 2); chk("addi_pc", rs_pc, 32'h100);
        step();
        chk("addi_after", rs_valid, 0);
        // dispatch and cdb0 in the same cycle
        disp(6'd3, 4, 0, 0, 0, 0, 1, 2); cdb0_en = 1'b1; cdb0_rob = 4'd2; cdb0_val = 32'h10;
        step(); disp_valid = 1'b0; cdb0_en = 1'b0;
        step();
        chk("byp_valid", rs_valid, 1); chk("byp_vk", rs_vk, 32'h10); chk("byp_vj", rs_vj, 4);
        step();
        // fill all 16 entries pending on rob 1
        for (int k = 0; k < 16; k++) begin
            chk("fill_notfull", rs_full, 0);
            disp(6'd4, 0, 0, k, 1, 1, 0, 0);
            step();
        end
        chk("full", rs_full, 1);
        disp(6'd4, 0, 0, 99, 0, 0, 0, 0);
        step(); disp_valid = 1'b0;
        chk("full_hold", rs_full, 1); chk("full_noissue", rs_valid, 0);
        cdb0_en = 1'b1; cdb0_rob = 4'd1; cdb0_val = 32'h55;
        step(); cdb0_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("drain_valid", rs_valid, 1); chk("drain_imm", rs_imm, k);
            chk("drain_vj", rs_vj, 32'h55);
        end
        step();
        chk("drain_done", rs_valid, 0); chk("drain_full", rs_full, 0);
        // flush wins over simultaneous dispatch
        for (int k = 0; k < 4; k++) begin
            disp(6'd5, 0, 0, k, 1, 5, 0, 0);
            step();
        end
        disp(6'd5, 0, 0, 77, 0, 0, 0, 0); flush = 1'b1;
        step(); disp_valid = 1'b0; flush = 1'b0;
        chk("flush_valid", rs_valid, 0); chk("flush_full", rs_full, 0);
        cdb0_en = 1'b1; cdb0_rob = 4'd5; cdb0_val = 1;
        step(); cdb0_en = 1'b0;
        step(); chk("flush_noissue1", rs_valid, 0);
        step(); chk("flush_noissue2", rs_valid, 0);
        // rdy low swallows a broadcast and freezes outputs
        disp(6'd6, 0, 0, 32'h77, 1, 7, 0, 0);
        step(); disp_valid = 1'b0;
        rdy = 1'b0; cdb0_en = 1'b1; cdb0_rob = 4'd7; cdb0_val = 32'hab;
        step(); rdy = 1'b1; cdb0_en = 1'b0;
        step(); chk("frz_nowake1", rs_valid, 0);
        step(); chk("frz_nowake2", rs_valid, 0);
        cdb0_en = 1'b1; cdb0_val = 32'hcd;
        step(); cdb0_en = 1'b0;
        step();
        chk("frz_issue", rs_valid, 1); chk("frz_imm", rs_imm, 32'h77); chk("frz_vj", rs_vj, 32'hcd);
        rdy = 1'b0;
        step();
        chk("frz_hold_valid", rs_valid, 1); chk("frz_hold_imm", rs_imm, 32'h77);
        rdy = 1'b1;
        step();
        chk("frz_release", rs_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
